// File: rtl/reg_dump.sv
// Register-file dump engine: walks a (possibly wrapping) index range, reads each register
// through a one-cycle-latency read port and streams {index, data, last} beats through a
// two-entry output FIFO with valid/ready flow control.
module reg_dump #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        first_reg,
  input  logic [4:0]        last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  // Issue side
  logic [4:0] issue_idx_q, issue_idx_d;    // next index to read
  logic [5:0] issue_left_q, issue_left_d;  // reads still to issue (1..32)
  logic [4:0] last_addr_q, last_addr_d;    // most recently issued index
  logic [4:0] span;
  logic       issue_en;
  logic       issue;
  logic [4:0] addr5;

  // Read in flight (address driven last cycle, data arrives this cycle)
  logic       infl_vld_q;
  logic [4:0] infl_idx_q;
  logic       infl_last_q;

  // Two-entry output FIFO
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [4:0]        fifo_idx_q  [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              push, pop;
  logic [2:0]        occ_after;

  logic done_q, done_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (issue && (issue_left_q == 6'd1)) state_d = StDrain;
      StDrain: if (pop && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != StIdle);
    issue_en = (state_q == StIssue);
  end

  // Issue credit: count this cycle's pop and the pending push so that every read issued now
  // is guaranteed a FIFO slot when its data lands next cycle, while still sustaining one
  // beat per cycle when the consumer never stalls.
  always_comb begin
    push      = infl_vld_q;
    pop       = out_valid && out_ready;
    occ_after = {1'b0, count_q} + {2'b00, infl_vld_q} - {2'b00, pop};
    issue     = issue_en && (occ_after < 3'd2);
    span      = last_reg - first_reg;
  end

  // Read address: the index being issued, otherwise the last one issued; zero when idle
  always_comb begin
    addr5 = issue ? issue_idx_q : last_addr_q;
    if (state_q == StIdle) addr5 = 5'd0;
    rd_addr = ADDR_W'(addr5);
  end

  // Issue-side next state: range capture on start, advance on each issued read
  always_comb begin
    issue_idx_d  = issue_idx_q;
    issue_left_d = issue_left_q;
    last_addr_d  = last_addr_q;
    if ((state_q == StIdle) && start) begin
      issue_idx_d  = first_reg;
      issue_left_d = {1'b0, span} + 6'd1;
    end else if (issue) begin
      issue_idx_d  = issue_idx_q + 5'd1;
      issue_left_d = issue_left_q - 6'd1;
      last_addr_d  = issue_idx_q;
    end
  end

  // Issue-side and in-flight registers
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_idx_q  <= 5'd0;
      issue_left_q <= 6'd0;
      last_addr_q  <= 5'd0;
      infl_vld_q   <= 1'b0;
      infl_idx_q   <= 5'd0;
      infl_last_q  <= 1'b0;
    end else begin
      issue_idx_q  <= issue_idx_d;
      issue_left_q <= issue_left_d;
      last_addr_q  <= last_addr_d;
      infl_vld_q   <= issue;
      infl_idx_q   <= issue_idx_q;
      infl_last_q  <= (issue_left_q == 6'd1);
    end
  end

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; captured read data enters the tail
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_idx_q[0]  <= 5'd0;
      fifo_idx_q[1]  <= 5'd0;
      fifo_last_q    <= 2'b00;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Output beat is the FIFO head
  always_comb begin
    out_valid = (count_q != 2'd0);
    out_data  = fifo_data_q[rd_ptr_q];
    out_index = fifo_idx_q[rd_ptr_q];
    out_last  = fifo_last_q[rd_ptr_q];
  end

  // Completion pulse follows acceptance of the final beat
  always_comb begin
    done_d = pop && out_last;
  end

  // Completion pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule
